cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of functional-unit requesters sharing the CDB.
REQ-002 Parameter ENTRY_W, default 3, ROB entry tag width.
REQ-003 Parameter DATA_W, default 32, result value width.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  ROB mispredict flush; squashes pending grant and CDB output.
REQ-007 req_valid  input  N_REQ  per-requester result-ready flag.
REQ-008 req_entry  input  N_REQ*ENTRY_W  per-requester ROB tag; requester i occupies slice [i*ENTRY_W +: ENTRY_W].
REQ-009 req_value  input  N_REQ*DATA_W  per-requester result; requester i occupies slice [i*DATA_W +: DATA_W].
REQ-010 req_ready  output  N_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-011 cdb_write  output  1  registered CDB broadcast strobe to the ROB and reservation stations.
REQ-012 cdb_entry  output  ENTRY_W  registered broadcast ROB tag.
REQ-013 cdb_value  output  DATA_W  registered broadcast value.

Function
REQ-014 req_ready is combinational: at most one bit high per cycle; all bits low when flush=1 or no req_valid bit is high.
REQ-015 Grant selection is round-robin: search starts at pointer ptr (ENTRY index 0..N_REQ-1) and takes the first i with req_valid[i]=1, wrapping from N_REQ-1 to 0.
REQ-016 On a transfer from requester g, ptr updates to (g+1) mod N_REQ on the same edge; without a transfer ptr holds.
REQ-017 Latency is one cycle: a transfer in cycle t yields cdb_write=1, cdb_entry=req_entry[g], cdb_value=req_value[g] in cycle t+1 only.
REQ-018 cdb_write is 0 in every cycle not preceded by a transfer; cdb_entry/cdb_value hold their last values when cdb_write=0.
REQ-019 Requesters hold req_valid, req_entry and req_value stable until granted; the arbiter does not buffer ungranted requests.
REQ-020 Throughput is one broadcast per cycle; back-to-back grants to different requesters produce consecutive cdb_write pulses.
REQ-021 Fairness: a requester holding req_valid=1 is granted within N_REQ cycles, provided flush stays low.
REQ-022 With flush=1 in cycle t: no transfer in t, cdb_write=0 in t+1, and ptr holds.
REQ-023 flush=1 in the cycle after a transfer forces cdb_write to 0 in that cycle, squashing the in-flight broadcast.
REQ-024 A requester whose req_valid drops without being granted is removed from arbitration with no side effect.

Reset
REQ-025 rst=1 sets ptr=0, cdb_write=0, cdb_entry=0 and cdb_value=0 on the next edge.
REQ-026 req_ready is all-zero while rst=1; a grant in progress when rst asserts is discarded.

Structure
REQ-027 The shared defines file holds ENTRY_W (as ROB_Entry_Width) and DATA_W (as Data_Width); this block adds no new global constants.
REQ-028 A sub-module rr_picker (combinational round-robin priority encoder: inputs valid vector and ptr; outputs one-hot grant and index) is used and is unit-testable on its own.

Verification
REQ-029 After reset, req_valid=4'b0101 held for 3 cycles -> grants 0, 2, 0 in successive cycles; cdb_write=1 in cycles 2-4 with the matching entry/value.
REQ-030 All four requesters valid continuously with distinct tags 1, 2, 3, 4 -> grant order 0, 1, 2, 3, 0 and cdb_entry sequence 1, 2, 3, 4, 1 with no idle cycle.
REQ-031 Requester 3 valid alone with value 0xDEADBEEF and tag 5 -> req_ready=4'b1000 the same cycle; cdb_write=1, cdb_entry=5, cdb_value=0xDEADBEEF next cycle.
REQ-032 Grant to requester 1 in cycle t with flush=1 in cycle t+1 -> cdb_write=0 in t+1 and no grant in t+1.
REQ-033 rst asserted mid-stream with all requesters valid -> next cycle cdb_write=0 and ptr=0; the first grant after release goes to requester 0.
REQ-034 Random valid patterns over 10k cycles -> never more than one req_ready bit high, no held request waits more than 4 cycles, and every transfer is broadcast exactly once.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus (CDB) arbiter slice.
// Latency: none (constants and elaboration-time helpers only).
// Backpressure: not applicable.
// ROB_Entry_Width and Data_Width are the machine-wide ROB tag and result widths.
package cdb_arbiter_pkg;

  localparam int ROB_Entry_Width = 3;
  localparam int Data_Width      = 32;

  // Width of a pointer that indexes n requesters. The result is never zero,
  // so a single-requester build still has a legal vector.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin priority encoder: first valid requester at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is all-zero when no valid bit is set.
// Ports: valid[N] request vector, ptr search start; grant[N] one-hot,
//        idx index of the granted requester, any high when a grant exists.
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      // ptr is always below N, so a single conditional subtract is enough.
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!any && valid[pos[PTR_W-1:0]]) begin
        any                    = 1'b1;
        grant[pos[PTR_W-1:0]]  = 1'b1;
        idx                    = pos[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one functional unit per cycle onto the CDB.
// Latency: one cycle from transfer to the registered broadcast.
// Backpressure: req_ready is a combinational one-hot grant; requests hold until granted.
// Ports: clk, rst (sync, active-high), flush; req_valid/req_entry/req_value per
//        requester; req_ready grant; cdb_write/cdb_entry/cdb_value broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ENTRY_W = ROB_Entry_Width,
  parameter int DATA_W  = Data_Width
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ENTRY_W-1:0]   req_entry,
  input  logic [N_REQ*DATA_W-1:0]    req_value,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       cdb_write,
  output logic [ENTRY_W-1:0]         cdb_entry,
  output logic [DATA_W-1:0]          cdb_value
);

  localparam int PTR_W = ptr_width(N_REQ);

  logic [PTR_W-1:0] ptr;
  logic [N_REQ-1:0] pick_grant;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             xfer;
  logic             write_q;

  rr_picker #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grants are suppressed during reset and flush, so no transfer can occur
  // then and the pointer holds.
  assign req_ready = (rst || flush) ? '0 : pick_grant;
  assign xfer      = pick_any && !rst && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      write_q   <= 1'b0;
      cdb_entry <= '0;
      cdb_value <= '0;
    end else begin
      write_q <= xfer;
      if (xfer) begin
        ptr       <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        cdb_entry <= req_entry[int'(pick_idx)*ENTRY_W +: ENTRY_W];
        cdb_value <= req_value[int'(pick_idx)*DATA_W +: DATA_W];
      end
    end
  end

  // A flush in the broadcast cycle kills the strobe of the in-flight result;
  // the tag/value registers keep what they captured, which is harmless
  // because consumers only look at them when cdb_write is high.
  assign cdb_write = write_q && !flush;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized checks of cdb_arbiter against hand-computed values
// and a small round-robin reference model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int EW = 3;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*EW-1:0] req_entry;
  logic [N*DW-1:0] req_value;
  logic [N-1:0]    req_ready;
  logic            cdb_write;
  logic [EW-1:0]   cdb_entry;
  logic [DW-1:0]   cdb_value;

  int n_vec = 0;
  int n_err = 0;

  cdb_arbiter #(.N_REQ(N), .ENTRY_W(EW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_entry (req_entry),
    .req_value (req_value),
    .req_ready (req_ready),
    .cdb_write (cdb_write),
    .cdb_entry (cdb_entry),
    .cdb_value (cdb_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [EW-1:0] e, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_entry[i*EW +: EW]  = e;
    req_value[i*DW +: DW]  = d;
  endtask

  // Reference model state for the randomized phase.
  int          mptr;
  int          exp_g;
  int          max_wait;
  int          waitc [N];
  logic [N-1:0] exp_ready;
  logic        prev_xfer;
  logic [EW-1:0] prev_e;
  logic [DW-1:0] prev_v;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_entry = '0;
    req_value = '0;
    tick();
    req_valid = 4'b1111;
    mid();
    chk("ready_in_rst", 64'(req_ready), 64'(4'b0000));
    tick();
    req_valid = '0;
    rst = 1'b0;

    // Reset state
    mid();
    chk("rst_write", 64'(cdb_write), 64'(1'b0));
    chk("rst_entry", 64'(cdb_entry), 64'(3'd0));
    chk("rst_value", 64'(cdb_value), 64'(32'd0));
    chk("rst_ready_idle", 64'(req_ready), 64'(4'b0000));
    tick();

    // Valid pattern 0101 held three cycles: grants 0, 2, 0.
    set_req(0, 1'b1, 3'd1, 32'h100);
    set_req(2, 1'b1, 3'd3, 32'h300);
    mid();
    chk("p0101_g0", 64'(req_ready), 64'(4'b0001));
    chk("p0101_w0", 64'(cdb_write), 64'(1'b0));
    tick();
    mid();
    chk("p0101_g1", 64'(req_ready), 64'(4'b0100));
    chk("p0101_w1", 64'(cdb_write), 64'(1'b1));
    chk("p0101_e1", 64'(cdb_entry), 64'(3'd1));
    chk("p0101_v1", 64'(cdb_value), 64'(32'h100));
    tick();
    mid();
    chk("p0101_g2", 64'(req_ready), 64'(4'b0001));
    chk("p0101_e2", 64'(cdb_entry), 64'(3'd3));
    chk("p0101_v2", 64'(cdb_value), 64'(32'h300));
    tick();
    req_valid = '0;
    mid();
    chk("p0101_g3", 64'(req_ready), 64'(4'b0000));
    chk("p0101_w3", 64'(cdb_write), 64'(1'b1));
    chk("p0101_e3", 64'(cdb_entry), 64'(3'd1));
    tick();
    mid();
    chk("idle_write", 64'(cdb_write), 64'(1'b0));
    chk("idle_hold_e", 64'(cdb_entry), 64'(3'd1));
    chk("idle_hold_v", 64'(cdb_value), 64'(32'h100));
    tick();

    // Pointer is 1: requester 3 retracts without a grant and leaves no trace.
    set_req(2, 1'b1, 3'd2, 32'h222);
    set_req(3, 1'b1, 3'd6, 32'h666);
    mid();
    chk("retract_g", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = '0;
    mid();
    chk("retract_ready", 64'(req_ready), 64'(4'b0000));
    chk("retract_e", 64'(cdb_entry), 64'(3'd2));
    tick();
    mid();
    chk("retract_w", 64'(cdb_write), 64'(1'b0));
    chk("retract_e_hold", 64'(cdb_entry), 64'(3'd2));
    tick();

    // Reset clears the pointer, then all four valid: 0,1,2,3,0 back to back.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(i + 1), 32'hA0 + 32'(i));
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("all_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      if (k > 0) begin
        chk("all_write", 64'(cdb_write), 64'(1'b1));
        chk("all_entry", 64'(cdb_entry), 64'(((k - 1) % 4) + 1));
      end
      tick();
    end
    req_valid = '0;
    mid();
    chk("all_last_w", 64'(cdb_write), 64'(1'b1));
    chk("all_last_e", 64'(cdb_entry), 64'(3'd1));
    chk("all_last_v", 64'(cdb_value), 64'(32'hA0));
    tick();

    // Requester 3 alone: same-cycle grant, broadcast next cycle.
    set_req(3, 1'b1, 3'd5, 32'hDEADBEEF);
    mid();
    chk("solo3_g", 64'(req_ready), 64'(4'b1000));
    tick();
    req_valid = '0;
    mid();
    chk("solo3_w", 64'(cdb_write), 64'(1'b1));
    chk("solo3_e", 64'(cdb_entry), 64'(3'd5));
    chk("solo3_v", 64'(cdb_value), 64'(32'hDEADBEEF));
    tick();

    // Grant to requester 1, then flush squashes the broadcast.
    set_req(1, 1'b1, 3'd7, 32'h777);
    mid();
    chk("fl_g1", 64'(req_ready), 64'(4'b0010));
    tick();
    flush = 1'b1;
    mid();
    chk("fl_ready", 64'(req_ready), 64'(4'b0000));
    chk("fl_write", 64'(cdb_write), 64'(1'b0));
    tick();
    flush = 1'b0;
    req_valid = '0;
    mid();
    chk("fl_after_w", 64'(cdb_write), 64'(1'b0));
    tick();

    // Flush with all valid: no transfer, pointer (2) holds.
    req_valid = 4'b1111;
    flush = 1'b1;
    mid();
    chk("flh_ready", 64'(req_ready), 64'(4'b0000));
    tick();
    flush = 1'b0;
    mid();
    chk("flh_write", 64'(cdb_write), 64'(1'b0));
    chk("flh_ptr", 64'(req_ready), 64'(4'b0100));
    tick();

    // Reset mid-stream with everything valid.
    rst = 1'b1;
    mid();
    chk("mrst_ready", 64'(req_ready), 64'(4'b0000));
    tick();
    rst = 1'b0;
    mid();
    chk("mrst_write", 64'(cdb_write), 64'(1'b0));
    chk("mrst_entry", 64'(cdb_entry), 64'(3'd0));
    chk("mrst_value", 64'(cdb_value), 64'(32'd0));
    chk("mrst_first", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    mid();
    chk("mrst_bcast", 64'(cdb_entry), 64'(3'd1));
    tick();

    // Randomized phase: pointer is 1, nothing in flight.
    mptr      = 1;
    prev_xfer = 1'b0;
    prev_e    = '0;
    prev_v    = '0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      mid();
      exp_g = -1;
      for (int k = 0; k < N; k++) begin
        if (exp_g < 0 && req_valid[(mptr + k) % N]) exp_g = (mptr + k) % N;
      end
      exp_ready = (exp_g >= 0) ? (4'b0001 << exp_g) : 4'b0000;
      chk("rnd_onehot", 64'($countones(req_ready) <= 1), 64'(1));
      chk("rnd_ready", 64'(req_ready), 64'(exp_ready));
      chk("rnd_write", 64'(cdb_write), 64'(prev_xfer));
      if (prev_xfer) begin
        chk("rnd_entry", 64'(cdb_entry), 64'(prev_e));
        chk("rnd_value", 64'(cdb_value), 64'(prev_v));
      end
      max_wait = 0;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !req_ready[i]) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > max_wait) max_wait = waitc[i];
      end
      chk("rnd_fair", 64'(max_wait <= N - 1), 64'(1));
      prev_xfer = (exp_g >= 0);
      if (exp_g >= 0) begin
        prev_e = req_entry[exp_g*EW +: EW];
        prev_v = req_value[exp_g*DW +: DW];
        mptr   = (exp_g + 1) % N;
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if (exp_ready[i] || !req_valid[i]) begin
          set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
